// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle control FSM.
// States, opcode map, control-word layout and trap causes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMCOMP  = 4'd2,
    S_MEMRD    = 4'd3,
    S_WB       = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RCOMP    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IEXEC_SE = 4'd10,
    S_IEXEC_ZE = 4'd11,
    S_TRAP     = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    C_NOOP,
    C_RTYPE,
    C_JUMP,
    C_BRANCH,
    C_IMM_SE,
    C_IMM_ZE,
    C_LI,
    C_LOAD,
    C_STORE,
    C_ILLEGAL
  } opclass_e;

  localparam logic [5:0] OP_NOOP   = 6'h00;
  localparam logic [5:0] OP_J      = 6'h01;
  localparam logic [5:0] OP_R_LO   = 6'h10;
  localparam logic [5:0] OP_R_HI   = 6'h17;
  localparam logic [5:0] OP_BR_LO  = 6'h21;
  localparam logic [5:0] OP_BR_HI  = 6'h23;
  localparam logic [5:0] OP_ISE_LO = 6'h32;
  localparam logic [5:0] OP_ISE_HI = 6'h33;
  localparam logic [5:0] OP_IZE_LO = 6'h34;
  localparam logic [5:0] OP_IZE_HI = 6'h37;
  localparam logic [5:0] OP_LI     = 6'h39;
  localparam logic [5:0] OP_LWI    = 6'h3B;
  localparam logic [5:0] OP_SWI    = 6'h3C;
  localparam logic [5:0] OP_LW     = 6'h3D;

  localparam int CW_PCWRITECOND = 15;
  localparam int CW_PCWRITE     = 14;
  localparam int CW_IORD        = 13;
  localparam int CW_MEMREAD     = 12;
  localparam int CW_MEMWRITE    = 11;
  localparam int CW_MEMTOREG    = 10;
  localparam int CW_IRWRITE     = 9;
  localparam int CW_PCSRC_LSB   = 7;
  localparam int CW_ALUOP_LSB   = 5;
  localparam int CW_ALUSRCB_LSB = 3;
  localparam int CW_ALUSRCA     = 2;
  localparam int CW_REGWRITE    = 1;
  localparam int CW_REGDST      = 0;

  localparam logic [15:0] CW_FETCH   = 16'h5208;
  localparam logic [15:0] CW_DECODE  = 16'h0010;
  localparam logic [15:0] CW_MEMCOMP = 16'h0074;
  localparam logic [15:0] CW_MEMRD   = 16'h3000;
  localparam logic [15:0] CW_WB      = 16'h0422;
  localparam logic [15:0] CW_MEMWR   = 16'h2834;
  localparam logic [15:0] CW_EXEC    = 16'h0024;
  localparam logic [15:0] CW_IEXEC   = 16'h0034;
  localparam logic [15:0] CW_RCOMP   = 16'h0002;
  localparam logic [15:0] CW_BRANCH  = 16'h80DC;
  localparam logic [15:0] CW_JUMP    = 16'h4100;
  localparam logic [15:0] CW_TRAP    = 16'h0000;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  function automatic logic [15:0] cw_of(state_e s);
    case (s)
      S_FETCH:    return CW_FETCH;
      S_DECODE:   return CW_DECODE;
      S_MEMCOMP:  return CW_MEMCOMP;
      S_MEMRD:    return CW_MEMRD;
      S_WB:       return CW_WB;
      S_MEMWR:    return CW_MEMWR;
      S_EXEC:     return CW_EXEC;
      S_IEXEC_SE: return CW_IEXEC;
      S_IEXEC_ZE: return CW_IEXEC;
      S_RCOMP:    return CW_RCOMP;
      S_BRANCH:   return CW_BRANCH;
      S_JUMP:     return CW_JUMP;
      default:    return CW_TRAP;
    endcase
  endfunction

  // Whether the opcode now on the bus may legally own this state.
  function automatic logic op_ok(state_e s, opclass_e c);
    case (s)
      S_DECODE:   return c != C_ILLEGAL;
      S_MEMCOMP:  return c inside {C_LI, C_LOAD, C_STORE};
      S_MEMRD:    return c == C_LOAD;
      S_WB:       return c == C_LOAD;
      S_MEMWR:    return c == C_STORE;
      S_EXEC:     return c == C_RTYPE;
      S_IEXEC_SE: return c == C_IMM_SE;
      S_IEXEC_ZE: return c == C_IMM_ZE;
      S_RCOMP:    return c inside {C_RTYPE, C_IMM_SE, C_IMM_ZE, C_LI};
      S_BRANCH:   return c == C_BRANCH;
      S_JUMP:     return c == C_JUMP;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_opcode_class.sv
// mc_opcode_class: combinational opcode-to-class decoder.
// Shared by DECODE routing and the mid-instruction legality checks.
module mc_opcode_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [3:0] o_class
);

  always_comb begin
    o_class = C_ILLEGAL;
    unique case (1'b1)
      i_opcode == OP_NOOP:
        o_class = C_NOOP;
      i_opcode == OP_J:
        o_class = C_JUMP;
      i_opcode >= OP_R_LO && i_opcode <= OP_R_HI:
        o_class = C_RTYPE;
      i_opcode >= OP_BR_LO && i_opcode <= OP_BR_HI:
        o_class = C_BRANCH;
      i_opcode >= OP_ISE_LO && i_opcode <= OP_ISE_HI:
        o_class = C_IMM_SE;
      i_opcode >= OP_IZE_LO && i_opcode <= OP_IZE_HI:
        o_class = C_IMM_ZE;
      i_opcode == OP_LI:
        o_class = C_LI;
      i_opcode == OP_LWI || i_opcode == OP_LW:
        o_class = C_LOAD;
      i_opcode == OP_SWI:
        o_class = C_STORE;
      default:
        o_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM with memory handshake and sticky trap.
// Optional performance counters: define MC_CTRL_PERF_CNT_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [15:0]      ctrl_word,
  output logic [3:0]       state_o,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] TO_LIM = 8'(MEM_TIMEOUT);

  state_e     r_state;
  logic       r_trap;
  logic [1:0] r_cause;
  logic [7:0] r_wait;
  logic [3:0] w_class_raw;
  opclass_e   w_cls;
  logic       w_mem_st;
  logic       w_waiting;
  logic       w_timeout;
  logic       w_bad_op;

  mc_opcode_class u_cls (
    .i_opcode (opcode),
    .o_class  (w_class_raw)
  );

  assign w_cls     = opclass_e'(w_class_raw);
  assign w_mem_st  = (r_state == S_FETCH) ||
                     (r_state == S_MEMRD) ||
                     (r_state == S_MEMWR);
  assign w_waiting = w_mem_st && !mem_ready;
  assign w_timeout = w_waiting && (r_wait == TO_LIM);
  assign w_bad_op  = !op_ok(r_state, w_cls);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_trap  <= 1'b0;
      r_cause <= TC_NONE;
      r_wait  <= 8'd0;
    end else begin
      r_wait <= w_waiting ? r_wait + 8'd1 : 8'd0;
      if (w_bad_op) begin
        r_state <= S_TRAP;
        r_trap  <= 1'b1;
        r_cause <= TC_ILLEGAL;
      end else if (w_timeout) begin
        r_state <= S_TRAP;
        r_trap  <= 1'b1;
        r_cause <= TC_TIMEOUT;
      end else begin
        case (r_state)
          S_FETCH:
            if (mem_ready) r_state <= S_DECODE;
          S_DECODE:
            case (w_cls)
              C_NOOP:   r_state <= S_FETCH;
              C_RTYPE:  r_state <= S_EXEC;
              C_JUMP:   r_state <= S_JUMP;
              C_BRANCH: r_state <= S_BRANCH;
              C_IMM_SE: r_state <= S_IEXEC_SE;
              C_IMM_ZE: r_state <= S_IEXEC_ZE;
              default:  r_state <= S_MEMCOMP;
            endcase
          S_MEMCOMP:
            case (w_cls)
              C_LI:    r_state <= S_RCOMP;
              C_LOAD:  r_state <= S_MEMRD;
              default: r_state <= S_MEMWR;
            endcase
          S_MEMRD:
            if (mem_ready) r_state <= S_WB;
          S_MEMWR:
            if (mem_ready) r_state <= S_FETCH;
          S_EXEC, S_IEXEC_SE, S_IEXEC_ZE:
            r_state <= S_RCOMP;
          S_WB, S_RCOMP, S_BRANCH, S_JUMP:
            r_state <= S_FETCH;
          S_TRAP:
            r_state <= S_TRAP;
          default:
            r_state <= S_TRAP;
        endcase
      end
    end
  end

  // PC/IR writes in FETCH wait for the memory to deliver the word.
  always_comb begin
    ctrl_word = 16'h0000;
    if (!reset) begin
      ctrl_word = cw_of(r_state);
      if (r_state == S_FETCH && !mem_ready) begin
        ctrl_word[CW_PCWRITE] = 1'b0;
        ctrl_word[CW_IRWRITE] = 1'b0;
      end
    end
  end

  assign state_o    = r_state;
  assign trap       = r_trap;
  assign trap_cause = r_cause;

`ifdef MC_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_stalls;
  logic             w_retire;

  assign w_retire = !w_bad_op && (
    (r_state == S_DECODE && w_cls == C_NOOP) ||
    (r_state == S_MEMWR && mem_ready) ||
    (r_state == S_WB) || (r_state == S_RCOMP) ||
    (r_state == S_BRANCH) || (r_state == S_JUMP));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
      r_stalls  <= '0;
    end else begin
      if (w_retire && !(&r_retired))
        r_retired <= r_retired + ONE;
      if (w_waiting && !(&r_stalls))
        r_stalls <= r_stalls + ONE;
    end
  end

  assign instr_retired = r_retired;
  assign stall_cycles  = r_stalls;
`else
  assign instr_retired = '0;
  assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed and random checks of mc_ctrl_fsm
// against a path-table model of instruction execution.
module tb_mc_ctrl_fsm;

  localparam int TO   = 4;
  localparam int CW   = 16;
  localparam int CMAX = 65535;
`ifdef MC_CTRL_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = 6'h00;
  logic          mem_ready = 1'b1;
  logic [15:0]   ctrl_word;
  logic [3:0]    state_o;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instr_retired;
  logic [CW-1:0] stall_cycles;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .ctrl_word     (ctrl_word),
    .state_o       (state_o),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .instr_retired (instr_retired),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Class index: 0 NOOP,1 R,2 J,3 BR,4 ISE,5 IZE,6 LI,7 LOAD,8 STORE,9 ILL
  int plen [10] = '{2, 4, 3, 3, 4, 4, 4, 5, 4, 0};
  int path [10][5] = '{
    '{0, 1, 0, 0, 0}, '{0, 1, 6, 7, 0}, '{0, 1, 9, 0, 0},
    '{0, 1, 8, 0, 0}, '{0, 1, 10, 7, 0}, '{0, 1, 11, 7, 0},
    '{0, 1, 2, 7, 0}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0},
    '{0, 0, 0, 0, 0}};

  logic [5:0] opl [18] = '{6'h00, 6'h01, 6'h10, 6'h12, 6'h17,
    6'h21, 6'h23, 6'h32, 6'h33, 6'h34, 6'h37, 6'h39, 6'h3B,
    6'h3C, 6'h3D, 6'h3F, 6'h02, 6'h20};

  function automatic int cls_of(logic [5:0] op);
    if (op == 6'h00) return 0;
    if (op >= 6'h10 && op <= 6'h17) return 1;
    if (op == 6'h01) return 2;
    if (op >= 6'h21 && op <= 6'h23) return 3;
    if (op == 6'h32 || op == 6'h33) return 4;
    if (op >= 6'h34 && op <= 6'h37) return 5;
    if (op == 6'h39) return 6;
    if (op == 6'h3B || op == 6'h3D) return 7;
    if (op == 6'h3C) return 8;
    return 9;
  endfunction

  function automatic logic [15:0] exp_cw(int s, logic rst, logic rdy);
    if (rst) return 16'h0000;
    case (s)
      0:       return rdy ? 16'h5208 : 16'h1008;
      1:       return 16'h0010;
      2:       return 16'h0074;
      3:       return 16'h3000;
      4:       return 16'h0422;
      5:       return 16'h2834;
      6:       return 16'h0024;
      7:       return 16'h0002;
      8:       return 16'h80DC;
      9:       return 16'h4100;
      10, 11:  return 16'h0034;
      default: return 16'h0000;
    endcase
  endfunction

  int         m_state = 0;
  int         m_step = 0;
  int         m_wait = 0;
  bit         m_trap = 1'b0;
  logic [1:0] m_cause = 2'b00;
  int         m_ret = 0;
  int         m_stl = 0;

  function automatic bit is_stall(int s, logic rdy);
    return (s == 0 || s == 3 || s == 5) && !rdy;
  endfunction

  function automatic bit is_bad(int s, int st, logic [5:0] op);
    int c = cls_of(op);
    if (st == 0) return 1'b0;
    if (plen[c] <= st) return 1'b1;
    return path[c][st] != s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0; m_step <= 0; m_wait <= 0;
      m_trap <= 1'b0; m_cause <= 2'b00;
      m_ret <= 0; m_stl <= 0;
    end else if (!m_trap) begin
      if (is_stall(m_state, mem_ready))
        m_stl <= (m_stl == CMAX) ? CMAX : m_stl + 1;
      if (is_bad(m_state, m_step, opcode)) begin
        m_state <= 15; m_trap <= 1'b1; m_cause <= 2'b01;
      end else if (is_stall(m_state, mem_ready) && m_wait == TO) begin
        m_state <= 15; m_trap <= 1'b1; m_cause <= 2'b10;
      end else if (is_stall(m_state, mem_ready)) begin
        m_wait <= m_wait + 1;
      end else begin
        m_wait <= 0;
        if (m_step == 0) begin
          m_step <= 1; m_state <= 1;
        end else if (m_step + 1 >= plen[cls_of(opcode)]) begin
          m_step <= 0; m_state <= 0;
          m_ret <= (m_ret == CMAX) ? CMAX : m_ret + 1;
        end else begin
          m_step <= m_step + 1;
          m_state <= path[cls_of(opcode)][m_step + 1];
        end
      end
    end
  end

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      lit("state_o", 32'(state_o), m_state);
      lit("ctrl_word", 32'(ctrl_word),
          32'(exp_cw(m_state, reset, mem_ready)));
      lit("trap", 32'(trap), 32'(m_trap));
      lit("trap_cause", 32'(trap_cause), 32'(m_cause));
      lit("instr_retired", 32'(instr_retired), PERF * m_ret);
      lit("stall_cycles", 32'(stall_cycles), PERF * m_stl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(int es, logic [15:0] ecw);
    @(negedge clk);
    lit("lit_state", 32'(state_o), es);
    lit("lit_cw", 32'(ctrl_word), 32'(ecw));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic to_memwr();
    opcode = 6'h3C; mem_ready = 1'b1;
    cyc(0, 16'h5208); cyc(1, 16'h0010); cyc(2, 16'h0074);
  endtask

  int lowrun = 0;

  initial begin
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // ADD, no waits
    do_reset();
    opcode = 6'h12; mem_ready = 1'b1;
    cyc(0, 16'h5208); cyc(1, 16'h0010);
    cyc(6, 16'h0024); cyc(7, 16'h0002);
    @(negedge clk);
    lit("add_end", 32'(state_o), 0);
    lit("add_ret", 32'(instr_retired), PERF);
    tick();

    // LW with three wait cycles in MEMRD
    do_reset();
    opcode = 6'h3D; mem_ready = 1'b1;
    cyc(0, 16'h5208); cyc(1, 16'h0010); cyc(2, 16'h0074);
    mem_ready = 1'b0;
    repeat (3) cyc(3, 16'h3000);
    mem_ready = 1'b1;
    cyc(3, 16'h3000); cyc(4, 16'h0422);
    @(negedge clk);
    lit("lw_end", 32'(state_o), 0);
    lit("lw_stall", 32'(stall_cycles), PERF * 3);
    lit("lw_ret", 32'(instr_retired), PERF);
    tick();

    // FETCH waiting on memory
    do_reset();
    mem_ready = 1'b0;
    cyc(0, 16'h1008); cyc(0, 16'h1008);
    mem_ready = 1'b1;
    cyc(0, 16'h5208);
    @(negedge clk);
    lit("fetch_dec", 32'(state_o), 1);
    lit("fetch_stall", 32'(stall_cycles), PERF * 2);
    tick();

    // Illegal opcode is absorbing
    do_reset();
    opcode = 6'h3F; mem_ready = 1'b1;
    cyc(0, 16'h5208); cyc(1, 16'h0010);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      @(negedge clk);
      lit("ill_state", 32'(state_o), 15);
      lit("ill_cw", 32'(ctrl_word), 0);
      lit("ill_cause", 32'({trap, trap_cause}), 3'b101);
      tick();
    end

    // SWI memory timeout after TO waits plus one
    do_reset();
    to_memwr();
    mem_ready = 1'b0;
    repeat (TO + 1) cyc(5, 16'h2834);
    @(negedge clk);
    lit("to_state", 32'(state_o), 15);
    lit("to_cause", 32'({trap, trap_cause}), 3'b110);
    lit("to_stall", 32'(stall_cycles), PERF * (TO + 1));
    tick();

    // Ready arriving on the boundary cycle wins
    do_reset();
    to_memwr();
    mem_ready = 1'b0;
    repeat (TO) cyc(5, 16'h2834);
    mem_ready = 1'b1;
    cyc(5, 16'h2834);
    @(negedge clk);
    lit("bnd_state", 32'(state_o), 0);
    lit("bnd_trap", 32'(trap), 0);
    lit("bnd_ret", 32'(instr_retired), PERF);
    tick();

    // Reset in the middle of MEMWR
    do_reset();
    to_memwr();
    mem_ready = 1'b0;
    cyc(5, 16'h2834); cyc(5, 16'h2834);
    reset = 1'b1;
    @(negedge clk);
    lit("rst_cw", 32'(ctrl_word), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    lit("rst_state", 32'(state_o), 0);
    lit("rst_trap", 32'({trap, trap_cause}), 0);
    lit("rst_cnt", 32'({instr_retired, stall_cycles}), 0);
    tick();
    opcode = 6'h00; mem_ready = 1'b1;
    cyc(0, 16'h5208); cyc(1, 16'h0010);
    @(negedge clk);
    lit("rst_noop", 32'(state_o), 0);
    lit("rst_ret", 32'(instr_retired), PERF);
    tick();

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (m_trap)
        reset = ($urandom_range(0, 3) == 0);
      else
        reset = ($urandom_range(0, 299) == 0);
      if (m_state == 0 || $urandom_range(0, 39) == 0)
        opcode = opl[$urandom_range(0, 17)];
      if (lowrun > 0) begin
        mem_ready = 1'b0;
        lowrun--;
      end else if ($urandom_range(0, 19) == 0) begin
        lowrun = $urandom_range(1, 7);
        mem_ready = 1'b0;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
